display_frame_sequencer: RTL and testbench

DISPLAY_FRAME_SEQUENCER -- requirements
Module: display_frame_sequencer

---
 rtl/display_pkg.sv | 23 ++
 rtl/pulse_stretcher.sv | 54 +++++
 rtl/display_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_display_frame_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and state encoding for the display frame sequencer.
// Also hosts the counter-width helper used by the sequencer and its timer.
package display_pkg;

  localparam int WORDS_PER_LINE_DEF  = 40;
  localparam int LINES_PER_FRAME_DEF = 1024;
  localparam int UPDATE_CYCLES_DEF   = 4;
  localparam int LINE_COUNT_W        = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_STREAM    = 3'd2,
    ST_UPDATE    = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // A counter for n states never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Holds the display latch strobe high for UPDATE_CYCLES clocks.
// last_o marks the final strobe cycle so the sequencer can close the frame.
module pulse_stretcher
  import display_pkg::*;
#(
  parameter int UPDATE_CYCLES = UPDATE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clear_i,
  output logic active_o,
  output logic last_o
);

  localparam int CW = cnt_w(UPDATE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(UPDATE_CYCLES - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active_o = active_q;
  assign last_o   = active_q & (cnt_q == LAST);

endmodule

// File: rtl/display_frame_sequencer.sv
// Streams lines from the sc32 FIFO to the display driver, then strobes
// the display latch and flips DC-balance polarity once per frame.
module display_frame_sequencer
  import display_pkg::*;
#(
  parameter int WORDS_PER_LINE  = WORDS_PER_LINE_DEF,
  parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF,
  parameter int UPDATE_CYCLES   = UPDATE_CYCLES_DEF
) (
  input  logic        fpga_clk,
  input  logic        reset_all_n,
  input  logic        enable,
  input  logic        frame_abort,
  input  logic        line_of_data_available,
  input  logic        get_next_word,
  output logic        sc32_fifo_read_enable,
  output logic        line_start,
  output logic        update,
  output logic        invert,
  output logic        frame_done,
  output logic [10:0] line_count,
  output logic        underrun
);

  localparam int WW = cnt_w(WORDS_PER_LINE);
  localparam int LW = cnt_w(LINES_PER_FRAME);
  localparam logic [WW-1:0] WLAST = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LLAST = LW'(LINES_PER_FRAME - 1);

  state_e        state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [LW-1:0] line_q, line_d;
  logic          invert_q, invert_d;
  logic          line_start_q, line_start_d;
  logic          frame_done_q, frame_done_d;
  logic          underrun_q, underrun_d;
  logic          upd_start, upd_last, upd_active;
  logic          accept;

  assign accept = get_next_word & (state_q == ST_STREAM);

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    line_d       = line_q;
    invert_d     = invert_q;
    underrun_d   = underrun_q;
    line_start_d = 1'b0;
    frame_done_d = 1'b0;
    upd_start    = 1'b0;
    if (frame_abort) begin
      state_d    = ST_IDLE;
      word_d     = '0;
      line_d     = '0;
      underrun_d = 1'b0;
    end else begin
      if (get_next_word && state_q != ST_STREAM)
        underrun_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (enable)
            state_d = ST_WAIT_LINE;
        end
        ST_WAIT_LINE: begin
          if (line_of_data_available) begin
            state_d      = ST_STREAM;
            line_start_d = 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (word_q == WLAST) begin
              word_d = '0;
              if (line_q == LLAST) begin
                line_d    = '0;
                state_d   = ST_UPDATE;
                upd_start = 1'b1;
              end else begin
                line_d  = line_q + LW'(1);
                state_d = ST_WAIT_LINE;
              end
            end else begin
              word_d = word_q + WW'(1);
            end
          end
        end
        ST_UPDATE: begin
          // enable is only sampled here, at the frame boundary
          if (upd_last) begin
            invert_d     = ~invert_q;
            frame_done_d = 1'b1;
            state_d      = enable ? ST_WAIT_LINE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (enable)
            state_d = ST_WAIT_LINE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      line_q       <= '0;
      invert_q     <= 1'b0;
      line_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      line_q       <= line_d;
      invert_q     <= invert_d;
      line_start_q <= line_start_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  pulse_stretcher #(
    .UPDATE_CYCLES(UPDATE_CYCLES)
  ) u_pulse (
    .clk_i   (fpga_clk),
    .rst_ni  (reset_all_n),
    .start_i (upd_start),
    .clear_i (frame_abort),
    .active_o(upd_active),
    .last_o  (upd_last)
  );

  assign sc32_fifo_read_enable = accept;
  assign line_start            = line_start_q;
  assign update                = upd_active;
  assign invert                = invert_q;
  assign frame_done            = frame_done_q;
  assign line_count            = LINE_COUNT_W'(line_q);
  assign underrun              = underrun_q;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed and random checks of display_frame_sequencer against a
// cycle-level behavioural model built from the sequencing rules.
module tb_display_frame_sequencer;

  localparam int W = 4;
  localparam int L = 2;
  localparam int U = 4;

  logic        fpga_clk = 1'b0;
  logic        reset_all_n;
  logic        enable;
  logic        frame_abort;
  logic        avail;
  logic        gnw;
  logic        rd;
  logic        ls;
  logic        upd;
  logic        inv;
  logic        fd;
  logic [10:0] lc;
  logic        und;

  display_frame_sequencer #(
    .WORDS_PER_LINE (W),
    .LINES_PER_FRAME(L),
    .UPDATE_CYCLES  (U)
  ) dut (
    .fpga_clk              (fpga_clk),
    .reset_all_n           (reset_all_n),
    .enable                (enable),
    .frame_abort           (frame_abort),
    .line_of_data_available(avail),
    .get_next_word         (gnw),
    .sc32_fifo_read_enable (rd),
    .line_start            (ls),
    .update                (upd),
    .invert                (inv),
    .frame_done            (fd),
    .line_count            (lc),
    .underrun              (und)
  );

  always #5 fpga_clk = ~fpga_clk;

  int tests = 0;
  int failed = 0;

  // model: phase 0 idle,1 waiting,2 streaming,3 latching,4 holding
  int m_ph, m_words, m_line, m_left, m_inv, m_ls, m_fd, m_und;
  int n_rd, n_ls, n_upd, n_fd, n_req;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_words = 0; m_line = 0; m_left = 0;
    m_inv = 0; m_ls = 0; m_fd = 0; m_und = 0;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_ls = 0; n_upd = 0; n_fd = 0; n_req = 0;
  endtask

  task automatic check_outputs();
    int exp_rd;
    exp_rd = (gnw === 1'b1 && m_ph == 2) ? 1 : 0;
    chk("read_enable", rd, exp_rd);
    chk("line_start", ls, m_ls);
    chk("update", upd, (m_ph == 3) ? 1 : 0);
    chk("invert", inv, m_inv);
    chk("frame_done", fd, m_fd);
    chk("line_count", lc, m_line);
    chk("underrun", und, m_und);
    if (rd === 1'b1) n_rd++;
    if (ls === 1'b1) n_ls++;
    if (upd === 1'b1) n_upd++;
    if (fd === 1'b1) n_fd++;
    n_req += exp_rd;
  endtask

  task automatic model_step();
    int nls, nfd;
    nls = 0; nfd = 0;
    if (frame_abort) begin
      m_ph = 0; m_words = 0; m_line = 0; m_left = 0; m_und = 0;
    end else begin
      if (gnw && m_ph != 2) m_und = 1;
      case (m_ph)
        0: if (enable) m_ph = 1;
        1: if (avail) begin m_ph = 2; nls = 1; end
        2: if (gnw) begin
             m_words++;
             if (m_words == W) begin
               m_words = 0;
               if (m_line == L - 1) begin
                 m_line = 0; m_ph = 3; m_left = U;
               end else begin
                 m_line++; m_ph = 1;
               end
             end
           end
        3: begin
             m_left--;
             if (m_left == 0) begin
               m_inv = 1 - m_inv; nfd = 1;
               m_ph = enable ? 1 : 4;
             end
           end
        default: if (enable) m_ph = 1;
      endcase
    end
    m_ls = nls;
    m_fd = nfd;
  endtask

  task automatic cyc();
    @(negedge fpga_clk);
    check_outputs();
    @(posedge fpga_clk);
    model_step();
    #1;
  endtask

  task automatic run_to_fd(input string tag);
    int i;
    i = 0;
    while (m_fd == 0 && i < 300) begin cyc(); i++; end
    chk({tag, "_reached_frame_done"}, (m_fd != 0), 1);
    cyc();
  endtask

  task automatic abort_now();
    frame_abort = 1'b1;
    cyc();
    frame_abort = 1'b0;
  endtask

  initial begin
    int i;
    reset_all_n = 1'b0; enable = 1'b0; frame_abort = 1'b0;
    avail = 1'b0; gnw = 1'b0;
    model_reset();
    clear_counts();
    #12;
    check_outputs();
    @(posedge fpga_clk); #3 reset_all_n = 1'b1;
    cyc();

    // full frame
    clear_counts();
    enable = 1'b1; avail = 1'b1; gnw = 1'b1;
    run_to_fd("frameA");
    chk("frameA_reads", n_rd, W * L);
    chk("frameA_line_starts", n_ls, L);
    chk("frameA_update_cycles", n_upd, U);
    chk("frameA_frame_done", n_fd, 1);
    chk("frameA_invert", inv, 1);

    // back-to-back frame
    clear_counts();
    run_to_fd("frameB");
    chk("frameB_reads", n_rd, W * L);
    chk("frameB_frame_done", n_fd, 1);
    chk("frameB_invert", inv, 0);
    chk("frameB_line_wrap", lc, 0);

    // third frame, then abort two words into line 1
    run_to_fd("frameC");
    i = 0;
    while (!(m_ph == 2 && m_line == 1 && m_words == 2) && i < 100) begin
      cyc(); i++;
    end
    chk("midline_reached", (m_line == 1 && m_words == 2), 1);
    enable = 1'b0;
    abort_now();
    chk("abort_line_count", lc, 0);
    chk("abort_invert_kept", inv, 1);
    chk("abort_update", upd, 0);
    chk("abort_underrun", und, 0);
    chk("abort_read_gated", rd, 0);
    gnw = 1'b0;
    cyc();

    // random traffic
    for (int k = 0; k < 800; k++) begin
      frame_abort = ($urandom_range(0, 63) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      avail       = $urandom_range(0, 1) != 0;
      gnw         = ($urandom_range(0, 2) != 0);
      cyc();
    end
    frame_abort = 1'b0; gnw = 1'b0; enable = 1'b0;
    abort_now();

    // gapped requests
    clear_counts();
    enable = 1'b1; avail = 1'b1;
    i = 0;
    while (n_rd < W && i < 100) begin
      gnw = (i % 2) != 0;
      cyc(); i++;
    end
    chk("gapped_reads", n_rd, W);
    chk("gapped_one_for_one", n_rd, n_req);
    chk("gapped_line_done", lc, 1);
    gnw = 1'b0; enable = 1'b0;
    abort_now();

    // underrun
    avail = 1'b0; enable = 1'b1;
    cyc();
    gnw = 1'b1;
    repeat (3) cyc();
    gnw = 1'b0;
    repeat (3) cyc();
    chk("underrun_sticky", und, 1);
    enable = 1'b0;
    abort_now();
    chk("underrun_cleared", und, 0);

    // async reset while latching
    enable = 1'b1; avail = 1'b1; gnw = 1'b1;
    i = 0;
    while (m_ph != 3 && i < 200) begin cyc(); i++; end
    cyc();
    chk("pre_reset_update", upd, 1);
    #2 reset_all_n = 1'b0;
    #1;
    chk("async_reset_update", upd, 0);
    chk("async_reset_line", lc, 0);
    chk("async_reset_underrun", und, 0);
    chk("async_reset_invert", inv, 0);
    model_reset();
    @(posedge fpga_clk); #3 reset_all_n = 1'b1;
    enable = 1'b0; gnw = 1'b0; avail = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
